axi_lite_regbank: RTL

AXI_LITE_REGBANK -- requirements
Module: axi_lite_regbank
Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 32, giving the AXI data width (32 or 64).
REQ-002 SHALL have parameter C_ADDR_WIDTH, default 6, giving the AXI byte-address width.
REQ-003 SHALL have parameter C_NUM_REGS, default 8, giving the number of word registers, 1..2^(C_ADDR_WIDTH-log2(C_DATA_WIDTH/8)).
REQ-004 SHALL have parameter C_RO_MASK, default 8'h80, width C_NUM_REGS; bit i set makes reg i a read-only status register.
REQ-005 SHALL have port S_AXI_ACLK, input, 1, the single clock.
REQ-006 SHALL have port S_AXI_ARESET, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port S_AXI_AWADDR, input, C_ADDR_WIDTH, write byte address.
REQ-008 SHALL have port S_AXI_AWVALID, input, 1, write address valid.
REQ-009 SHALL have port S_AXI_AWREADY, output, 1, write address ready.
REQ-010 SHALL have port S_AXI_WDATA, input, C_DATA_WIDTH, write data.
REQ-011 SHALL have port S_AXI_WSTRB, input, C_DATA_WIDTH/8, byte-lane enables.
REQ-012 SHALL have port S_AXI_WVALID, input, 1, write data valid.
REQ-013 SHALL have port S_AXI_WREADY, output, 1, write data ready.
REQ-014 SHALL have port S_AXI_BRESP, output, 2, write response.
REQ-015 SHALL have port S_AXI_BVALID, output, 1, write response valid.
REQ-016 SHALL have port S_AXI_BREADY, input, 1, write response ready.
REQ-017 SHALL have port S_AXI_ARADDR, input, C_ADDR_WIDTH, read byte address.
REQ-018 SHALL have port S_AXI_ARVALID, input, 1, read address valid.
REQ-019 SHALL have port S_AXI_ARREADY, output, 1, read address ready.
REQ-020 SHALL have port S_AXI_RDATA, output, C_DATA_WIDTH, read data.
REQ-021 SHALL have port S_AXI_RRESP, output, 2, read response.
REQ-022 SHALL have port S_AXI_RVALID, output, 1, read data valid.
REQ-023 SHALL have port S_AXI_RREADY, input, 1, read data ready.
REQ-024 SHALL have port reg_out, output, C_NUM_REGS*C_DATA_WIDTH, flattened register contents, reg i at bits [i*DW +: DW].
REQ-025 SHALL have port status_in, input, C_NUM_REGS*C_DATA_WIDTH, status values returned for read-only regs (lanes of RW regs ignored).
REQ-026 SHALL have port wr_strobe, output, C_NUM_REGS, one-cycle pulse on reg i when it is written.
Function
REQ-027 AW and W channels SHALL be captured independently in either order; AWREADY/WREADY high while the respective slot is empty and BVALID is low.
REQ-028 With both slots full, the write SHALL commit in the following cycle, with BVALID rising that same cycle and both slots cleared.
REQ-029 Register index SHALL be addr[C_ADDR_WIDTH-1:log2(DW/8)]; low address bits SHALL be ignored.
REQ-030 The write SHALL update only the byte lanes with WSTRB=1, pulse wr_strobe[idx] in the commit cycle, and return BRESP=OKAY (2'b00).
REQ-031 A write to index >= C_NUM_REGS or to a read-only reg SHALL leave all regs unchanged, give no wr_strobe pulse, and return BRESP=SLVERR (2'b10).
REQ-032 BVALID/BRESP SHALL hold until BREADY; no new AW/W SHALL be accepted while BVALID is high.
REQ-033 ARREADY SHALL be high while RVALID is low; after an AR handshake, RVALID SHALL rise in the next cycle with RDATA/RRESP registered.
REQ-034 Read data SHALL be the reg value for RW regs, or status_in sampled in the handshake cycle for read-only regs; out-of-range reads SHALL give RDATA=0 and RRESP=SLVERR.
REQ-035 RVALID/RDATA/RRESP SHALL hold stable until RREADY.
REQ-036 A read handshake in the same cycle as a write commit to the same reg SHALL return the pre-write value.
REQ-037 A parameter set violating the C_NUM_REGS bound of REQ-003 SHALL raise an elaboration-time error.
REQ-038 Read and write paths SHALL operate concurrently without mutual stalling.
Reset
REQ-039 While S_AXI_ARESET=1: all regs, RDATA and wr_strobe SHALL be 0; AWREADY, WREADY, ARREADY, BVALID and RVALID SHALL be 0; BRESP and RRESP SHALL be 0.
REQ-040 Reset asserted mid-transaction SHALL immediately drop all valids and discard captured AW/W/AR state; ready outputs SHALL go high on the first clock edge after release.
Structure
REQ-041 The package axi_lite_pkg SHALL hold the RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 constants and an index-width function.
REQ-042 The byte-lane merge SHALL be the sub-module axi_lite_strb_merge (old, new, strb -> merged).
Verification
REQ-043 Write 0x0101FFFF/0xABCD0001/0xDEADXXXX-free 0xDEAD0011/0xBEEF0011 to 0x00/0x04/0x08/0x0C, then read back -> identical data, all responses OKAY.
REQ-044 Write 0x12345678 to 0x00 (holding 0x0101FFFF) with WSTRB=4'b0011 -> readback 0x01015678; wr_strobe[0] high for exactly one cycle.
REQ-045 Present W three cycles before AW and hold BREADY low five cycles -> exactly one commit, BVALID/BRESP held, AWREADY=WREADY=0 until B handshake.
REQ-046 Write to 0x1C (RO) -> SLVERR with reg 7 unchanged; read 0x1C with status_in reg7=0xCAFE0000 -> 0xCAFE0000 OKAY; read 0x20 -> RDATA 0, SLVERR.
REQ-047 Assert ARESET with BVALID and RVALID high -> both drop at once, reg_out=0, and a write after release to 0x04 succeeds.

---
 rtl/axi_lite_pkg.sv | 12 +
 rtl/axi_lite_strb_merge.sv | 18 +
 rtl/axi_lite_regbank.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite response codes and register index sizing
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Register index width: byte-address bits left after dropping the in-word offset.
  function automatic int idx_width(input int addr_w, input int data_w);
    return addr_w - $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_lite_strb_merge.sv
// rtl/axi_lite_strb_merge.sv - byte-lane merge of new write data over an old word
module axi_lite_strb_merge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   old_i,
  input  logic [DW-1:0]   new_i,
  input  logic [DW/8-1:0] strb_i,
  output logic [DW-1:0]   merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < DW / 8; b++) begin
      if (strb_i[b]) merged_o[b*8 +: 8] = new_i[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axi_lite_regbank.sv
// rtl/axi_lite_regbank.sv - AXI-Lite slave register bank with read-only status slots
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int                    C_DATA_WIDTH = 32,
  parameter int                    C_ADDR_WIDTH = 6,
  parameter int                    C_NUM_REGS   = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = 8'h80
) (
  input  logic                               S_AXI_ACLK,
  input  logic                               S_AXI_ARESET,
  input  logic [C_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] status_in,
  output logic [C_NUM_REGS-1:0]              wr_strobe
);

  localparam int DW    = C_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int LSB   = $clog2(SW);
  localparam int IDX_W = idx_width(C_ADDR_WIDTH, DW);

  if (!(DW == 32 || DW == 64)) begin : g_bad_dw
    $error("axi_lite_regbank: C_DATA_WIDTH must be 32 or 64");
  end
  if (C_NUM_REGS < 1 || C_NUM_REGS > (1 << IDX_W)) begin : g_bad_num_regs
    $error("axi_lite_regbank: C_NUM_REGS outside 1..2^index_width");
  end

  logic                  rdy_en_q;
  logic                  aw_full_q, w_full_q, bvalid_q, rvalid_q;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DW-1:0]         w_data_q, rdata_q, rdata_d;
  logic [SW-1:0]         w_strb_q;
  logic [1:0]            bresp_q, rresp_q, rresp_d;
  logic [DW-1:0]         regs_q [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] wr_strobe_q, aw_hit, ar_hit;
  logic [DW-1:0]         old_word, merged_word;
  logic [IDX_W-1:0]      ar_idx;
  logic                  aw_hs, w_hs, ar_hs, commit, wr_ok;
  logic                  unused_addr_bits;

  // rdy_en_q keeps every ready low through reset and raises them on the first edge after release.
  assign S_AXI_AWREADY = rdy_en_q & ~aw_full_q & ~bvalid_q;
  assign S_AXI_WREADY  = rdy_en_q & ~w_full_q & ~bvalid_q;
  assign S_AXI_ARREADY = rdy_en_q & ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_strobe     = wr_strobe_q;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_full_q & w_full_q;
  assign ar_idx = S_AXI_ARADDR[C_ADDR_WIDTH-1:LSB];
  assign wr_ok  = |(aw_hit & ~C_RO_MASK);
  assign unused_addr_bits = ^{S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DW +: DW] = regs_q[g];
  end

  always_comb begin
    aw_hit   = '0;
    ar_hit   = '0;
    old_word = '0;
    rdata_d  = '0;
    rresp_d  = RESP_SLVERR;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      aw_hit[i] = (aw_idx_q == i[IDX_W-1:0]);
      ar_hit[i] = (ar_idx == i[IDX_W-1:0]);
      if (aw_hit[i]) old_word = regs_q[i];
      if (ar_hit[i]) begin
        rresp_d = RESP_OKAY;
        rdata_d = C_RO_MASK[i] ? status_in[i*DW +: DW] : regs_q[i];
      end
    end
  end

  axi_lite_strb_merge #(.DW(DW)) u_strb_merge (
    .old_i    (old_word),
    .new_i    (w_data_q),
    .strb_i   (w_strb_q),
    .merged_o (merged_word)
  );

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rdy_en_q    <= 1'b0;
      aw_full_q   <= 1'b0;
      aw_idx_q    <= '0;
      w_full_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      wr_strobe_q <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      rdy_en_q    <= 1'b1;
      wr_strobe_q <= '0;
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= S_AXI_AWADDR[C_ADDR_WIDTH-1:LSB];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_full_q   <= 1'b0;
        w_full_q    <= 1'b0;
        bvalid_q    <= 1'b1;
        bresp_q     <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        wr_strobe_q <= aw_hit & ~C_RO_MASK;
        for (int i = 0; i < C_NUM_REGS; i++) begin
          if (aw_hit[i] && !C_RO_MASK[i]) regs_q[i] <= merged_word;
        end
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule
